// File: rtl/cpu_nic.sv
// cpu_nic: responder side of the processor NIC access port.
// One 64-bit input channel buffer (router -> core) and one 64-bit output
// channel buffer (core -> router), each with a full flag the core can poll.
// Optional feature macro: CPU_NIC_POLARITY_EN (virtual-channel phase gating
// of the output channel through the net_polarity port).
module cpu_nic #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  nicEn,
   input  logic                  nicEnWr,
   input  logic [ADDR_WIDTH-1:0] adder_nic,
   input  logic [DATA_WIDTH-1:0] nic_dataIn,
   output logic [DATA_WIDTH-1:0] nic_dataOut,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di
`ifdef CPU_NIC_POLARITY_EN
   ,
   input  logic                  net_polarity
`endif
);

   localparam logic [ADDR_WIDTH-1:0] SEL_IN_BUF  = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] SEL_IN_STAT = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] SEL_OUT_BUF = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] SEL_OUT_STAT = ADDR_WIDTH'(3);

   logic [DATA_WIDTH-1:0] in_buf;
   logic [DATA_WIDTH-1:0] out_buf;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  in_full;
   logic                  out_full;
   logic                  rd_en;
   logic                  wr_en;
   logic                  send;
   logic                  recv;

   assign rd_en = nicEn & ~nicEnWr;
   assign wr_en = nicEn & nicEnWr;

`ifdef CPU_NIC_POLARITY_EN
   // A packet is offered only while its phase bit matches the router phase.
   assign net_so = out_full & (out_buf[DATA_WIDTH-1] == net_polarity);
`else
   assign net_so = out_full;
`endif
   assign net_do = out_buf;
   assign net_ri = ~in_full;

   assign send = net_so & net_ro;
   assign recv = net_si & ~in_full;

   // Read mux: status bits are the pre-edge flag values.
   always_comb begin
      rd_data = '0;
      unique case (adder_nic)
         SEL_IN_BUF:   rd_data = in_buf;
         SEL_IN_STAT:  rd_data = DATA_WIDTH'(in_full);
         SEL_OUT_BUF:  rd_data = '0;
         SEL_OUT_STAT: rd_data = DATA_WIDTH'(out_full);
         default:      rd_data = '0;
      endcase
   end

   // Output channel: accept a core write only when empty, drain on handshake.
   // Fill and drain are exclusive because both depend on the pre-edge flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_buf  <= '0;
         out_full <= 1'b0;
      end else if (wr_en && (adder_nic == SEL_OUT_BUF) && !out_full) begin
         out_buf  <= nic_dataIn;
         out_full <= 1'b1;
      end else if (send) begin
         out_full <= 1'b0;
      end
   end

   // Input channel: capture from the router when empty, release on core read.
   // Arrival requires in_full=0, so it can never collide with a release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_buf  <= '0;
         in_full <= 1'b0;
      end else if (recv) begin
         in_buf  <= net_di;
         in_full <= 1'b1;
      end else if (rd_en && (adder_nic == SEL_IN_BUF)) begin
         in_full <= 1'b0;
      end
   end

   // Registered read port; zero on every edge without a read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nic_dataOut <= '0;
      end else if (rd_en) begin
         nic_dataOut <= rd_data;
      end else begin
         nic_dataOut <= '0;
      end
   end

endmodule

// File: tb/tb_cpu_nic.sv
// Testbench for cpu_nic: directed vector table for the NIC access and
// channel handshakes, then randomized traffic checked against a queue-based
// model of the two single-entry channels.
module tb_cpu_nic;

   logic        clk = 1'b0;
   logic        rst;
   logic        nicEn, nicEnWr;
   logic [1:0]  adder_nic;
   logic [63:0] nic_dataIn, nic_dataOut;
   logic        net_so, net_ro, net_si, net_ri;
   logic [63:0] net_do, net_di;
   logic        net_polarity;

   int checks = 0;
   int errors = 0;

   cpu_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .nicEn(nicEn), .nicEnWr(nicEnWr),
      .adder_nic(adder_nic), .nic_dataIn(nic_dataIn), .nic_dataOut(nic_dataOut),
      .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
`ifdef CPU_NIC_POLARITY_EN
      , .net_polarity(net_polarity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, wr;
      logic [1:0]  addr;
      logic [63:0] din;
      logic        ro, si;
      logic [63:0] di;
      logic        pol;
      logic [63:0] e_dout;
      logic        e_so, e_ri;
      logic [63:0] e_do;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic en, wr, input logic [1:0] a,
                              input logic [63:0] din, input logic ro, si,
                              input logic [63:0] di, input logic pol,
                              input logic [63:0] e_dout, input logic e_so, e_ri,
                              input logic [63:0] e_do);
      vec_t r;
      r.en = en; r.wr = wr; r.addr = a; r.din = din; r.ro = ro; r.si = si;
      r.di = di; r.pol = pol; r.e_dout = e_dout; r.e_so = e_so; r.e_ri = e_ri;
      r.e_do = e_do;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one access/transfer set, then sample 1 time unit after the edge.
   task automatic apply(input logic en, wr, input logic [1:0] a, input logic [63:0] d,
                        input logic ro, si, input logic [63:0] di, input logic pol);
      nicEn = en; nicEnWr = wr; adder_nic = a; nic_dataIn = d;
      net_ro = ro; net_si = si; net_di = di; net_polarity = pol;
      @(posedge clk);
      #1;
   endtask

   // Reference model: each channel is a queue holding at most one packet.
   logic [63:0] m_in_q[$];
   logic [63:0] m_out_q[$];
   logic [63:0] m_in_last, m_out_last, m_dout;

   task automatic model_reset();
      m_in_q.delete(); m_out_q.delete();
      m_in_last = '0; m_out_last = '0; m_dout = '0;
   endtask

   function automatic logic model_so(input logic pol);
`ifdef CPU_NIC_POLARITY_EN
      return (m_out_q.size() != 0) && (m_out_last[63] == pol);
`else
      return (m_out_q.size() != 0);
`endif
   endfunction

   task automatic model_check(input string tag);
      chk({tag, ".dout"}, nic_dataOut, m_dout);
      chk({tag, ".so"}, {63'b0, net_so}, {63'b0, model_so(net_polarity)});
      chk({tag, ".ri"}, {63'b0, net_ri}, {63'b0, m_in_q.size() == 0});
      chk({tag, ".do"}, net_do, m_out_last);
   endtask

   task automatic model_step(input string tag, input logic en, wr, input logic [1:0] a,
                             input logic [63:0] d, input logic ro, si,
                             input logic [63:0] di, input logic pol);
      logic rd, do_send, do_write, do_pop, do_accept;
      rd = en && !wr;
      m_dout = '0;
      if (rd) begin
         case (a)
            2'd0: m_dout = m_in_last;
            2'd1: m_dout = 64'(m_in_q.size());
            2'd2: m_dout = '0;
            default: m_dout = 64'(m_out_q.size());
         endcase
      end
      do_send   = model_so(pol) && ro;
      do_write  = en && wr && (a == 2'd2) && (m_out_q.size() == 0);
      do_pop    = rd && (a == 2'd0) && (m_in_q.size() != 0);
      do_accept = si && (m_in_q.size() == 0);
      if (do_send) void'(m_out_q.pop_front());
      if (do_write) begin m_out_q.push_back(d); m_out_last = d; end
      if (do_pop) void'(m_in_q.pop_front());
      if (do_accept) begin m_in_q.push_back(di); m_in_last = di; end
      apply(en, wr, a, d, ro, si, di, pol);
      model_check(tag);
   endtask

   localparam logic [63:0] P1 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      rst = 1'b1;
      nicEn = 0; nicEnWr = 0; adder_nic = 0; nic_dataIn = 0;
      net_ro = 0; net_si = 0; net_di = 0; net_polarity = 0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("reset.dout", nic_dataOut, 64'h0);
      chk("reset.so", {63'b0, net_so}, 64'h0);
      chk("reset.ri", {63'b0, net_ri}, 64'h1);
      chk("reset.do", net_do, 64'h0);
      @(negedge clk);

      //       en wr a    din   ro si di        pol  e_dout       so ri e_do
      vecs.push_back(v(1, 0, 2'd1, 0,     0, 0, 0,        0,   0,          0, 1, 0));
      vecs.push_back(v(1, 0, 2'd3, 0,     0, 0, 0,        0,   0,          0, 1, 0));
      vecs.push_back(v(1, 1, 2'd2, P1,    0, 0, 0,        1,   0,          1, 1, P1));
      vecs.push_back(v(1, 0, 2'd3, 0,     0, 0, 0,        1,   1,          1, 1, P1));
      vecs.push_back(v(0, 0, 2'd0, 0,     1, 0, 0,        1,   0,          0, 1, P1));
      vecs.push_back(v(1, 0, 2'd3, 0,     0, 0, 0,        1,   0,          0, 1, P1));
      vecs.push_back(v(1, 1, 2'd2, P1,    0, 0, 0,        1,   0,          1, 1, P1));
      vecs.push_back(v(1, 1, 2'd2, 64'h2, 0, 0, 0,        1,   0,          1, 1, P1));
      vecs.push_back(v(1, 1, 2'd2, 64'h3, 1, 0, 0,        1,   0,          0, 1, P1));
      vecs.push_back(v(1, 0, 2'd3, 0,     0, 0, 0,        1,   0,          0, 1, P1));
      vecs.push_back(v(0, 0, 2'd0, 0,     0, 1, 64'h1234, 0,   0,          0, 0, P1));
      vecs.push_back(v(1, 0, 2'd1, 0,     0, 1, 64'h5678, 0,   1,          0, 0, P1));
      vecs.push_back(v(1, 0, 2'd0, 0,     0, 1, 64'h5678, 0,   64'h1234,   0, 1, P1));
      vecs.push_back(v(0, 0, 2'd0, 0,     0, 1, 64'h5678, 0,   0,          0, 0, P1));
      vecs.push_back(v(1, 0, 2'd0, 0,     0, 0, 0,        0,   64'h5678,   0, 1, P1));
      vecs.push_back(v(1, 0, 2'd2, 0,     0, 0, 0,        0,   0,          0, 1, P1));
      vecs.push_back(v(1, 1, 2'd2, 64'hB, 0, 0, 0,        0,   0,          1, 1, 64'hB));
      vecs.push_back(v(1, 0, 2'd3, 0,     1, 1, 64'hA,    0,   1,          0, 0, 64'hB));
      vecs.push_back(v(1, 0, 2'd0, 0,     0, 0, 0,        0,   64'hA,      0, 1, 64'hB));
      vecs.push_back(v(1, 1, 2'd1, FF,    0, 0, 0,        0,   0,          0, 1, 64'hB));
      vecs.push_back(v(1, 1, 2'd3, FF,    0, 0, 0,        0,   0,          0, 1, 64'hB));
      vecs.push_back(v(1, 1, 2'd0, FF,    0, 0, 0,        0,   0,          0, 1, 64'hB));
      vecs.push_back(v(1, 0, 2'd1, 0,     0, 0, 0,        0,   0,          0, 1, 64'hB));
      vecs.push_back(v(1, 0, 2'd3, 0,     0, 0, 0,        0,   0,          0, 1, 64'hB));
      vecs.push_back(v(1, 0, 2'd0, 0,     0, 0, 0,        0,   64'hA,      0, 1, 64'hB));

      foreach (vecs[i]) begin
         apply(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din,
               vecs[i].ro, vecs[i].si, vecs[i].di, vecs[i].pol);
         chk($sformatf("vec%0d.dout", i), nic_dataOut, vecs[i].e_dout);
         chk($sformatf("vec%0d.so", i), {63'b0, net_so}, {63'b0, vecs[i].e_so});
         chk($sformatf("vec%0d.ri", i), {63'b0, net_ri}, {63'b0, vecs[i].e_ri});
         chk($sformatf("vec%0d.do", i), net_do, vecs[i].e_do);
      end

      // Asynchronous reset mid-cycle with both buffers full and dout nonzero.
      apply(1, 1, 2'd2, 64'h55, 0, 1, 64'h77, 0);
      apply(1, 0, 2'd1, 0, 0, 0, 0, 0);
      chk("pre_rst.dout", nic_dataOut, 64'h1);
      chk("pre_rst.so", {63'b0, net_so}, 64'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst.dout", nic_dataOut, 64'h0);
      chk("async_rst.so", {63'b0, net_so}, 64'h0);
      chk("async_rst.ri", {63'b0, net_ri}, 64'h1);
      chk("async_rst.do", net_do, 64'h0);
      #2 rst = 1'b0;
      model_reset();
      model_step("post_rst_rd01", 1, 0, 2'd1, 0, 0, 0, 0, 0);
      model_step("post_rst_rd11", 1, 0, 2'd3, 0, 0, 0, 0, 0);

      // Randomized traffic against the channel model.
      for (int unsigned n = 0; n < 400; n++) begin
         model_step("rand", 1'($urandom), 1'($urandom), 2'($urandom),
                    {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                    {$urandom, $urandom}, 1'($urandom));
      end

`ifdef CPU_NIC_POLARITY_EN
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      model_step("pol_wr", 1, 1, 2'd2, 64'h8000_0000_0000_0007, 1, 0, 0, 0);
      chk("pol_wait.so", {63'b0, net_so}, 64'h0);
      model_step("pol_hold", 0, 0, 2'd0, 0, 1, 0, 0, 0);
      net_polarity = 1'b1;
      #1;
      chk("pol_match.so", {63'b0, net_so}, 64'h1);
      model_step("pol_send", 0, 0, 2'd0, 0, 1, 0, 0, 1);
      chk("pol_sent.so", {63'b0, net_so}, 64'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
